l2c_mem_port_arbiter: RTL and testbench
=======================================

// Module: l2c_mem_port_arbiter
// PURPOSE
//  Shares the single L2-to-main-memory port between the five L2 memory clients:
//  inst dirty write-back, inst line fill, data dirty write-back, data line fill,
//  and write-buffer drain. Sits between the L2 cache controller FSMs and the
//  memory interface. Grants one client at a time, sequences a fixed-length beat
//  burst, and returns a one-cycle done pulse. Drives grant_id as the L2 datapath
//  address/data mux select.
// PARAMETERS
//  ADDR_W     32  memory address width
//  BURST_LEN  4   beats per line transfer (power of 2, >=2)
//  HOLDOFF    2   cycles a served client's request is masked after its done pulse
// PORTS
//  clk_l2                 in   1       L2 clock; all logic on posedge
//  rst                    in   1       asynchronous, active-high reset
//  inst_mem_dirty_req     in   1       inst-side write-back request (level, held until done)
//  inst_mem_replace_req   in   1       inst-side line fill request (level)
//  inst_dirty_addr        in   ADDR_W  line address for inst write-back
//  inst_replace_addr      in   ADDR_W  line address for inst fill
//  data_mem_dirty_req     in   1       data-side write-back request (level)
//  data_mem_replace_req   in   1       data-side line fill request (level)
//  data_dirty_addr        in   ADDR_W  line address for data write-back
//  data_replace_addr      in   ADDR_W  line address for data fill
//  wb_drain_req           in   1       write-buffer drain request (level)
//  wb_urgent              in   1       write buffer full; promotes wb to top priority
//  wb_drain_addr          in   ADDR_W  line address for drain
//  mem_ack                in   1       memory accepted or returned one beat this cycle
//  inst_mem_dirty_done    out  1       1-cycle pulse: inst write-back complete
//  inst_mem_replace_done  out  1       1-cycle pulse: inst fill complete
//  data_mem_dirty_done    out  1       1-cycle pulse: data write-back complete
//  data_mem_replace_done  out  1       1-cycle pulse: data fill complete
//  wb_drain_done          out  1       1-cycle pulse: drain complete
//  mem_req                out  1       burst in progress
//  mem_we                 out  1       1 = write (dirty, drain); 0 = read (fill)
//  mem_addr               out  ADDR_W  latched line base address of granted client
//  mem_beat               out  log2(BURST_LEN)  index of the current beat
//  grant_id               out  3       0=none 1=i_dirty 2=i_repl 3=d_dirty 4=d_repl 5=wb
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; rr_ptr=INST; all holdoff masks cleared.
//  - FSM IDLE -> BURST -> DONE -> IDLE.
//  - IDLE: eligible = req & ~mask. Priority:
//    1. wb if wb_urgent.
//    2. Round-robin between sides by rr_ptr; inside a side, dirty before replace.
//    3. wb (non-urgent).
//    On a grant, the next edge latches grant_id, mem_addr and mem_we, sets mem_req=1,
//    clears mem_beat and enters BURST. mem_req rises 1 cycle after the request is seen.
//  - Side fall-through: if the pointed-to side has no eligible request, grant the other side.
//  - rr_ptr flips to the side opposite the one served at each inst/data grant.
//    wb grants leave rr_ptr unchanged.
//  - BURST: mem_req held. Each cycle with mem_ack=1 increments mem_beat (mod BURST_LEN).
//    mem_ack on beat BURST_LEN-1 -> DONE, and mem_req drops at that edge.
//    mem_ack=0 stalls indefinitely; there is no timeout.
//    Request inputs and addresses are ignored during BURST; the address is held from the latch.
//  - DONE (exactly 1 cycle): the granted client's done output is 1, mem_req=0 and grant_id is held.
//    Next edge -> IDLE, grant_id=0, and that client's mask counter is loaded with HOLDOFF.
//    This absorbs the registered request-drop latency of the controller FSMs.
//  - Mask counter decrements each cycle to 0. The client is ineligible while its counter is nonzero.
//    Other clients may be granted in the first IDLE cycle after DONE.
//  - mem_ack outside BURST is ignored.
//  - Reset mid-burst: immediate return to IDLE; no done pulse; mem_req=0 asynchronously.
//  - At most one done output is high in any cycle. Done outputs and mem_req are never high together.
// TESTING
//  - Single fill: data_mem_replace_req=1, addr=0x1000, mem_ack every cycle ->
//    mem_req high 4 cycles with mem_we=0, mem_beat 0..3, grant_id=4,
//    then data_mem_replace_done pulse 1 cycle.
//  - Simultaneous requests: inst_mem_replace_req and data_mem_dirty_req both high, rr_ptr=INST ->
//    inst granted first (grant_id=2), data next (grant_id=3, mem_we=1),
//    with one IDLE cycle between bursts.
//  - Urgent drain: wb_drain_req+wb_urgent together with inst_mem_dirty_req -> wb granted first (id 5).
//    With wb_urgent=0, wb is granted only after inst.
//  - Stall: mem_ack pattern 1,0,0,1,1,0,1 -> 4 beats counted; done asserts exactly after the 4th ack.
//  - Holdoff: client keeps its req high 2 cycles after its done -> no second grant.
//    A request still high on cycle 3 is re-granted.
//  - Reset mid-burst: assert rst at beat 2 -> mem_req=0, grant_id=0 immediately; no done pulse.
//    After release, the held request is re-granted from beat 0.

Source files
------------

// File: rtl/l2c_mem_port_arbiter.sv
// Arbitrates the single L2-to-memory port among five clients: it grants one
// client, runs a fixed-length beat burst for it, then pulses that client's done.
module l2c_mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int HOLDOFF   = 2
) (
    input  logic                         clk_l2,
    input  logic                         rst,
    input  logic                         inst_mem_dirty_req,
    input  logic                         inst_mem_replace_req,
    input  logic [ADDR_W-1:0]            inst_dirty_addr,
    input  logic [ADDR_W-1:0]            inst_replace_addr,
    input  logic                         data_mem_dirty_req,
    input  logic                         data_mem_replace_req,
    input  logic [ADDR_W-1:0]            data_dirty_addr,
    input  logic [ADDR_W-1:0]            data_replace_addr,
    input  logic                         wb_drain_req,
    input  logic                         wb_urgent,
    input  logic [ADDR_W-1:0]            wb_drain_addr,
    input  logic                         mem_ack,
    output logic                         inst_mem_dirty_done,
    output logic                         inst_mem_replace_done,
    output logic                         data_mem_dirty_done,
    output logic                         data_mem_replace_done,
    output logic                         wb_drain_done,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [$clog2(BURST_LEN)-1:0] mem_beat,
    output logic [2:0]                   grant_id
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int MW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [2:0] ID_NONE    = 3'd0;
    localparam logic [2:0] ID_I_DIRTY = 3'd1;
    localparam logic [2:0] ID_I_REPL  = 3'd2;
    localparam logic [2:0] ID_D_DIRTY = 3'd3;
    localparam logic [2:0] ID_D_REPL  = 3'd4;
    localparam logic [2:0] ID_WB      = 3'd5;

    localparam logic SIDE_INST = 1'b0;
    localparam logic SIDE_DATA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                rr_q, rr_d;
    logic [MW-1:0]       mask_q [5];
    logic [MW-1:0]       mask_d [5];

    logic [4:0]          req_vec;
    logic [4:0]          elig;
    logic [2:0]          inst_pick;
    logic [2:0]          data_pick;
    logic [2:0]          sel;
    logic [ADDR_W-1:0]   sel_addr;

    // Client bit k corresponds to grant_id k+1.
    assign req_vec = {wb_drain_req, data_mem_replace_req, data_mem_dirty_req,
                      inst_mem_replace_req, inst_mem_dirty_req};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            elig[i] = req_vec[i] && (mask_q[i] == '0);
        end
    end

    always_comb begin
        inst_pick = elig[0] ? ID_I_DIRTY : (elig[1] ? ID_I_REPL : ID_NONE);
        data_pick = elig[2] ? ID_D_DIRTY : (elig[3] ? ID_D_REPL : ID_NONE);
        sel       = ID_NONE;
        if (wb_urgent && elig[4]) begin
            sel = ID_WB;
        end else if (rr_q == SIDE_INST && inst_pick != ID_NONE) begin
            sel = inst_pick;
        end else if (data_pick != ID_NONE) begin
            sel = data_pick;
        end else if (inst_pick != ID_NONE) begin
            sel = inst_pick;
        end else if (elig[4]) begin
            sel = ID_WB;
        end
    end

    always_comb begin
        case (sel)
            ID_I_DIRTY: sel_addr = inst_dirty_addr;
            ID_I_REPL:  sel_addr = inst_replace_addr;
            ID_D_DIRTY: sel_addr = data_dirty_addr;
            ID_D_REPL:  sel_addr = data_replace_addr;
            ID_WB:      sel_addr = wb_drain_addr;
            default:    sel_addr = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        for (int i = 0; i < 5; i++) begin
            mask_d[i] = (mask_q[i] != '0) ? mask_q[i] - 1'b1 : '0;
        end

        case (state_q)
            S_IDLE: begin
                if (sel != ID_NONE) begin
                    state_d = S_BURST;
                    grant_d = sel;
                    addr_d  = sel_addr;
                    we_d    = (sel == ID_I_DIRTY) || (sel == ID_D_DIRTY) || (sel == ID_WB);
                    beat_d  = '0;
                    if (sel == ID_I_DIRTY || sel == ID_I_REPL) begin
                        rr_d = SIDE_DATA;
                    end else if (sel == ID_D_DIRTY || sel == ID_D_REPL) begin
                        rr_d = SIDE_INST;
                    end
                end
            end
            S_BURST: begin
                if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = ID_NONE;
                // Masking covers the cycles the client FSM needs to see done and drop its request.
                case (grant_q)
                    ID_I_DIRTY: mask_d[0] = MW'(HOLDOFF);
                    ID_I_REPL:  mask_d[1] = MW'(HOLDOFF);
                    ID_D_DIRTY: mask_d[2] = MW'(HOLDOFF);
                    ID_D_REPL:  mask_d[3] = MW'(HOLDOFF);
                    ID_WB:      mask_d[4] = MW'(HOLDOFF);
                    default:    ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
                grant_d = ID_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_l2 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= ID_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
            rr_q    <= SIDE_INST;
            for (int i = 0; i < 5; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
            for (int i = 0; i < 5; i++) begin
                mask_q[i] <= mask_d[i];
            end
        end
    end

    assign mem_req  = (state_q == S_BURST);
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_beat = beat_q;
    assign grant_id = grant_q;

    assign inst_mem_dirty_done   = (state_q == S_DONE) && (grant_q == ID_I_DIRTY);
    assign inst_mem_replace_done = (state_q == S_DONE) && (grant_q == ID_I_REPL);
    assign data_mem_dirty_done   = (state_q == S_DONE) && (grant_q == ID_D_DIRTY);
    assign data_mem_replace_done = (state_q == S_DONE) && (grant_q == ID_D_REPL);
    assign wb_drain_done         = (state_q == S_DONE) && (grant_q == ID_WB);

endmodule

// File: tb/tb_l2c_mem_port_arbiter.sv
// Bench for l2c_mem_port_arbiter: scenario tasks drive requests and push the
// expected grant order; a monitor pops and checks on each done pulse.
module tb_l2c_mem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int HOLDOFF   = 2;

    logic              clk_l2 = 1'b0;
    logic              rst = 1'b1;
    logic              inst_mem_dirty_req = 1'b0;
    logic              inst_mem_replace_req = 1'b0;
    logic [ADDR_W-1:0] inst_dirty_addr = '0;
    logic [ADDR_W-1:0] inst_replace_addr = '0;
    logic              data_mem_dirty_req = 1'b0;
    logic              data_mem_replace_req = 1'b0;
    logic [ADDR_W-1:0] data_dirty_addr = '0;
    logic [ADDR_W-1:0] data_replace_addr = '0;
    logic              wb_drain_req = 1'b0;
    logic              wb_urgent = 1'b0;
    logic [ADDR_W-1:0] wb_drain_addr = '0;
    logic              mem_ack = 1'b0;
    logic              inst_mem_dirty_done;
    logic              inst_mem_replace_done;
    logic              data_mem_dirty_done;
    logic              data_mem_replace_done;
    logic              wb_drain_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_beat;
    logic [2:0]        grant_id;

    l2c_mem_port_arbiter #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk_l2(clk_l2), .rst(rst),
        .inst_mem_dirty_req(inst_mem_dirty_req), .inst_mem_replace_req(inst_mem_replace_req),
        .inst_dirty_addr(inst_dirty_addr), .inst_replace_addr(inst_replace_addr),
        .data_mem_dirty_req(data_mem_dirty_req), .data_mem_replace_req(data_mem_replace_req),
        .data_dirty_addr(data_dirty_addr), .data_replace_addr(data_replace_addr),
        .wb_drain_req(wb_drain_req), .wb_urgent(wb_urgent), .wb_drain_addr(wb_drain_addr),
        .mem_ack(mem_ack),
        .inst_mem_dirty_done(inst_mem_dirty_done), .inst_mem_replace_done(inst_mem_replace_done),
        .data_mem_dirty_done(data_mem_dirty_done), .data_mem_replace_done(data_mem_replace_done),
        .wb_drain_done(wb_drain_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_beat(mem_beat),
        .grant_id(grant_id)
    );

    always #5 clk_l2 = ~clk_l2;

    typedef struct packed {
        logic [2:0]        id;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor state
    bit                in_burst = 1'b0;
    logic [2:0]        cur_id;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    int                exp_beat;
    logic [4:0]        dv;
    exp_t              e;

    always @(negedge clk_l2) begin
        if (rst) begin
            in_burst = 1'b0;
        end else begin
            dv = {wb_drain_done, data_mem_replace_done, data_mem_dirty_done,
                  inst_mem_replace_done, inst_mem_dirty_done};
            n_checks++;
            if ((dv != 5'b0) && mem_req) begin
                n_fail++;
                $display("FAIL done_with_req: done=%b mem_req=%b required mem_req=0", dv, mem_req);
            end
            n_checks++;
            if (!$onehot0(dv)) begin
                n_fail++;
                $display("FAIL done_onehot: done=%b required at most one bit", dv);
            end
            if (mem_req) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    cur_id   = grant_id;
                    cur_addr = mem_addr;
                    cur_we   = mem_we;
                    exp_beat = 0;
                end else begin
                    n_checks++;
                    if (grant_id !== cur_id || mem_addr !== cur_addr || mem_we !== cur_we) begin
                        n_fail++;
                        $display("FAIL burst_hold: id=%0d addr=%h we=%b required id=%0d addr=%h we=%b",
                                 grant_id, mem_addr, mem_we, cur_id, cur_addr, cur_we);
                    end
                end
                n_checks++;
                if (mem_beat !== 2'(exp_beat)) begin
                    n_fail++;
                    $display("FAIL beat_index: mem_beat=%0d required %0d", mem_beat, exp_beat);
                end
                if (mem_ack) exp_beat++;
            end
            if (dv != 5'b0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done=%b with empty scoreboard", dv);
                end else begin
                    e = sb_q.pop_front();
                    if (!in_burst || cur_id !== e.id || cur_addr !== e.addr || cur_we !== e.we ||
                        grant_id !== e.id || exp_beat != BURST_LEN ||
                        dv !== (5'b1 << (e.id - 3'd1))) begin
                        n_fail++;
                        $display("FAIL sb_txn: id=%0d addr=%h we=%b beats=%0d done=%b required id=%0d addr=%h we=%b beats=%0d",
                                 cur_id, cur_addr, cur_we, exp_beat, dv, e.id, e.addr, e.we, BURST_LEN);
                    end
                end
                in_burst = 1'b0;
            end
        end
    end

    task automatic serve(input int budget, output bit tmo);
        tmo = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_l2); #1;
            if (inst_mem_dirty_done)   inst_mem_dirty_req   = 1'b0;
            if (inst_mem_replace_done) inst_mem_replace_req = 1'b0;
            if (data_mem_dirty_done)   data_mem_dirty_req   = 1'b0;
            if (data_mem_replace_done) data_mem_replace_req = 1'b0;
            if (wb_drain_done)         wb_drain_req         = 1'b0;
            if (!(inst_mem_dirty_req | inst_mem_replace_req | data_mem_dirty_req |
                  data_mem_replace_req | wb_drain_req)) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_l2); #1;
        end
    endtask

    task automatic test_reset();
        idle(2);
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_beat !== 2'd0 ||
            grant_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h beat=%0d id=%0d required all 0",
                     mem_req, mem_we, mem_addr, mem_beat, grant_id);
        end
        n_checks++;
        if ({inst_mem_dirty_done, inst_mem_replace_done, data_mem_dirty_done,
             data_mem_replace_done, wb_drain_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_done: done outputs nonzero, required 0");
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_fill();
        int  nreq;
        bit  seen;
        sb_q.push_back('{id: 3'd4, addr: 32'h0000_1000, we: 1'b0});
        mem_ack = 1'b1;
        data_replace_addr = 32'h0000_1000;
        data_mem_replace_req = 1'b1;
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b1 || grant_id !== 3'd4 || mem_we !== 1'b0 ||
            mem_addr !== 32'h0000_1000 || mem_beat !== 2'd0) begin
            n_fail++;
            $display("FAIL fill_grant: req=%b id=%0d we=%b addr=%h beat=%0d required 1 4 0 00001000 0",
                     mem_req, grant_id, mem_we, mem_addr, mem_beat);
        end
        data_replace_addr = 32'hDEAD_0000;
        nreq = 1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_l2); #1;
            if (data_mem_replace_done) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) nreq++;
        end
        n_checks++;
        if (!seen || nreq != 4 || mem_req !== 1'b0 || grant_id !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_done: seen=%b req_cycles=%0d req=%b id=%0d required 1 4 0 4",
                     seen, nreq, mem_req, grant_id);
        end
        data_mem_replace_req = 1'b0;
        @(posedge clk_l2); #1;
        n_checks++;
        if (data_mem_replace_done !== 1'b0 || grant_id !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_pulse_width: done=%b id=%0d required 0 0", data_mem_replace_done, grant_id);
        end
    endtask

    task automatic test_simultaneous();
        bit seen;
        bit tmo;
        idle(3);
        sb_q.push_back('{id: 3'd2, addr: 32'h0000_2000, we: 1'b0});
        sb_q.push_back('{id: 3'd3, addr: 32'h0000_3000, we: 1'b1});
        inst_replace_addr = 32'h0000_2000;
        data_dirty_addr   = 32'h0000_3000;
        inst_mem_replace_req = 1'b1;
        data_mem_dirty_req   = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_l2); #1;
            if (inst_mem_replace_done) begin
                seen = 1'b1;
                break;
            end
        end
        inst_mem_replace_req = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL simul_first_done: seen=%b required 1", seen);
        end
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b0 || grant_id !== 3'd0) begin
            n_fail++;
            $display("FAIL simul_gap: req=%b id=%0d required 0 0", mem_req, grant_id);
        end
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b1 || grant_id !== 3'd3 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_second: req=%b id=%0d we=%b required 1 3 1", mem_req, grant_id, mem_we);
        end
        serve(20, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_timeout: tmo=%b required 0", tmo);
        end
    endtask

    task automatic test_urgent();
        bit tmo;
        idle(4);
        sb_q.push_back('{id: 3'd5, addr: 32'h0000_5000, we: 1'b1});
        sb_q.push_back('{id: 3'd1, addr: 32'h0000_1100, we: 1'b1});
        wb_drain_addr   = 32'h0000_5000;
        inst_dirty_addr = 32'h0000_1100;
        wb_urgent = 1'b1;
        wb_drain_req = 1'b1;
        inst_mem_dirty_req = 1'b1;
        @(posedge clk_l2); #1;
        n_checks++;
        if (grant_id !== 3'd5) begin
            n_fail++;
            $display("FAIL urgent_first: id=%0d required 5", grant_id);
        end
        serve(40, tmo);
        wb_urgent = 1'b0;
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL urgent_timeout: tmo=%b required 0", tmo);
        end
        idle(4);
        sb_q.push_back('{id: 3'd1, addr: 32'h0000_1200, we: 1'b1});
        sb_q.push_back('{id: 3'd5, addr: 32'h0000_5100, we: 1'b1});
        wb_drain_addr   = 32'h0000_5100;
        inst_dirty_addr = 32'h0000_1200;
        wb_drain_req = 1'b1;
        inst_mem_dirty_req = 1'b1;
        @(posedge clk_l2); #1;
        n_checks++;
        if (grant_id !== 3'd1) begin
            n_fail++;
            $display("FAIL nonurgent_first: id=%0d required 1", grant_id);
        end
        serve(40, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL nonurgent_timeout: tmo=%b required 0", tmo);
        end
    endtask

    task automatic test_stall();
        logic [6:0] pat;
        int         acks;
        pat = 7'b1011001;
        idle(4);
        mem_ack = 1'b0;
        sb_q.push_back('{id: 3'd3, addr: 32'h0000_3300, we: 1'b1});
        data_dirty_addr = 32'h0000_3300;
        data_mem_dirty_req = 1'b1;
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b1 || grant_id !== 3'd3 || mem_beat !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_grant: req=%b id=%0d beat=%0d required 1 3 0", mem_req, grant_id, mem_beat);
        end
        acks = 0;
        for (int i = 0; i < 7; i++) begin
            mem_ack = pat[i];
            @(posedge clk_l2); #1;
            acks += int'(pat[i]);
            n_checks++;
            if (i < 6) begin
                if (mem_req !== 1'b1 || data_mem_dirty_done !== 1'b0 || mem_beat !== 2'(acks)) begin
                    n_fail++;
                    $display("FAIL stall_step%0d: req=%b done=%b beat=%0d required 1 0 %0d",
                             i, mem_req, data_mem_dirty_done, mem_beat, acks);
                end
            end else begin
                if (data_mem_dirty_done !== 1'b1 || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_done: done=%b req=%b required 1 0", data_mem_dirty_done, mem_req);
                end
            end
        end
        mem_ack = 1'b1;
        data_mem_dirty_req = 1'b0;
        @(posedge clk_l2); #1;
        n_checks++;
        if (data_mem_dirty_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pulse_width: done=%b required 0", data_mem_dirty_done);
        end
    endtask

    task automatic test_holdoff();
        bit seen;
        bit tmo;
        idle(4);
        sb_q.push_back('{id: 3'd2, addr: 32'h0000_2200, we: 1'b0});
        sb_q.push_back('{id: 3'd2, addr: 32'h0000_2200, we: 1'b0});
        inst_replace_addr = 32'h0000_2200;
        inst_mem_replace_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_l2); #1;
            if (inst_mem_replace_done) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL holdoff_first_done: seen=%b required 1", seen);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_l2); #1;
            n_checks++;
            if (mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL holdoff_masked%0d: req=%b required 0", k, mem_req);
            end
        end
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b1 || grant_id !== 3'd2) begin
            n_fail++;
            $display("FAIL holdoff_regrant: req=%b id=%0d required 1 2", mem_req, grant_id);
        end
        serve(20, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff_timeout: tmo=%b required 0", tmo);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found;
        bit tmo;
        idle(4);
        mem_ack = 1'b1;
        data_replace_addr = 32'h0000_4400;
        data_mem_replace_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_l2); #1;
            if (mem_req && mem_beat == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_beat2: found=%b required 1", found);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || grant_id !== 3'd0 || mem_beat !== 2'd0 || data_mem_replace_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: req=%b id=%0d beat=%0d done=%b required 0 0 0 0",
                     mem_req, grant_id, mem_beat, data_mem_replace_done);
        end
        @(posedge clk_l2); #1;
        rst = 1'b0;
        sb_q.push_back('{id: 3'd4, addr: 32'h0000_4400, we: 1'b0});
        @(posedge clk_l2); #1;
        n_checks++;
        if (mem_req !== 1'b1 || grant_id !== 3'd4 || mem_beat !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_regrant: req=%b id=%0d beat=%0d required 1 4 0", mem_req, grant_id, mem_beat);
        end
        serve(20, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_timeout: tmo=%b required 0", tmo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fill();
        test_simultaneous();
        test_urgent();
        test_stall();
        test_holdoff();
        test_reset_mid_burst();
        idle(3);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d transactions left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
